// File: rtl/mul_iter_approx_pkg.sv
// Shared types and helpers for the iterative approximate multiplier.
// State encoding, truncation mask and compensation constant.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Widest operand the helpers can describe.
  localparam int MAXW = 32;

  typedef logic [2*MAXW-1:0] wide_t;

  // Mask over 2*width product bits, low trunc columns cleared.
  function automatic wide_t trunc_mask(input int width,
                                       input int trunc);
    wide_t w_lo;
    wide_t w_all;
    w_lo  = (wide_t'(1) << trunc) - wide_t'(1);
    // A shift of 2*MAXW wraps to 0, so -1 yields all ones.
    w_all = (wide_t'(1) << (2 * width)) - wide_t'(1);
    return ~w_lo & w_all;
  endfunction

  // Half of the dropped-column weight: 2^(trunc-1), 0 if none.
  function automatic wide_t comp_const(input int trunc);
    wide_t w_c;
    w_c = '0;
    if (trunc > 0)
      w_c = wide_t'(1) << (trunc - 1);
    return w_c;
  endfunction

endpackage

// File: rtl/mul_iter_approx_if.sv
// Operand/result handshake bundle for mul_iter_approx.
// master: producer/consumer side; slave: the multiplier.
interface mul_iter_approx_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_approx;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               out_approx;

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    output in_approx,
    input  out_valid,
    output out_ready,
    input  out_result,
    input  out_approx
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    input  in_approx,
    output out_valid,
    input  out_ready,
    output out_result,
    output out_approx
  );

endinterface

// File: rtl/mul_iter_approx_pp_gen.sv
// Partial-product generator: pp(i) = b[i] ? a << i : 0,
// low TRUNC columns cleared in approximate mode.
// Ports: i_a, i_b_bit, i_idx, i_approx -> o_pp (2*WIDTH).
module mul_pp_gen
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic               i_b_bit,
  input  logic [CW-1:0]      i_idx,
  input  logic               i_approx,
  output logic [2*WIDTH-1:0] o_pp
);

  localparam wide_t MASK_F = trunc_mask(WIDTH, TRUNC);
  localparam logic [2*WIDTH-1:0] MASK = MASK_F[2*WIDTH-1:0];

  logic [2*WIDTH-1:0] w_shift;

  assign w_shift = {{WIDTH{1'b0}}, i_a} << i_idx;

  always_comb begin
    o_pp = '0;
    if (i_b_bit)
      o_pp = i_approx ? (w_shift & MASK) : w_shift;
  end

endmodule

// File: rtl/mul_iter_approx.sv
// Sequential shift-add multiplier, one multiplier bit per cycle,
// optional column truncation. Ports: clk, rst, bus (slave).
module mul_iter_approx
  import mul_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TRUNC   = 4,
  parameter int COMP_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  mul_iter_approx_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam wide_t COMP_F = comp_const(TRUNC);
  localparam logic [2*WIDTH-1:0] COMP =
    (COMP_EN != 0) ? COMP_F[2*WIDTH-1:0] : '0;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || TRUNC < 0 || TRUNC > WIDTH ||
      WIDTH > MAXW) begin : g_bad_param
    $error("mul_iter_approx: illegal WIDTH/TRUNC");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_approx;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_result;
  logic               r_out_approx;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_zero;

  mul_pp_gen #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC),
    .CW    (CW)
  ) u_pp (
    .i_a      (r_a),
    .i_b_bit  (r_b[r_cnt]),
    .i_idx    (r_cnt),
    .i_approx (r_approx),
    .o_pp     (w_pp)
  );

  assign w_sum  = r_acc + w_pp;
  assign w_zero = (bus.in_a == '0) || (bus.in_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_approx     <= 1'b0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_result     <= '0;
      r_out_approx <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_approx   <= bus.in_approx;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            if (w_zero) begin
              // Result is known now; valid follows next edge.
              r_result     <= '0;
              r_out_approx <= bus.in_approx;
              r_state      <= DONE;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (r_cnt == LAST) begin
            r_result <= r_approx ? (w_sum + COMP) : w_sum;
            r_out_approx <= r_approx;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_result;
  assign bus.out_approx = r_out_approx;

endmodule

// File: tb/tb_mul_iter_approx.sv
// Directed + model-checked bench for mul_iter_approx,
// WIDTH=8, TRUNC=4, COMP_EN=1.
module tb_mul_iter_approx;

  localparam int W = 8;
  localparam int T = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mul_iter_approx_if #(.WIDTH(W)) bus ();

  mul_iter_approx #(
    .WIDTH   (W),
    .TRUNC   (T),
    .COMP_EN (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-level reference: sum a[j]&b[i] over columns >= T.
  function automatic logic [63:0] model(input int a,
                                        input int b,
                                        input bit ap);
    logic [63:0] s;
    s = 0;
    if (a == 0 || b == 0) return 0;
    if (!ap) return 64'(a * b);
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[j] && b[i] && (i + j) >= T)
          s += 64'(1) << (i + j);
    return s + 64'(1 << (T - 1));
  endfunction

  task automatic start(input int a, input int b, input bit ap);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    chk("in_ready_wait", 64'(w < 40), 64'(1));
    bus.in_valid  = 1'b1;
    bus.in_a      = W'(a);
    bus.in_b      = W'(b);
    bus.in_approx = ap;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_a      = '1;
    bus.in_b      = '1;
    bus.in_approx = ~ap;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic op(input string tag, input int a, input int b,
                    input bit ap, input logic [63:0] exp,
                    input int exp_lat);
    int lat;
    start(a, b, ap);
    wait_out(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(bus.out_result), exp);
    chk({tag, "_mode"}, 64'(bus.out_approx), 64'(ap));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    int lat;
    int a;
    int b;
    bit ap;
    longint err;
    n_chk = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_result", 64'(bus.out_result), 64'(0));
    chk("rst_approx", 64'(bus.out_approx), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    op("exact_ff", 255, 255, 1'b0, 64'd65025, 8);
    // Dropped columns 0..3 weigh 1+4+12+32 = 49; comp = 8.
    op("approx_ff", 255, 255, 1'b1, 64'd64984, 8);
    op("zero_a", 0, 200, 1'b1, 64'd0, 1);
    op("zero_b", 77, 0, 1'b0, 64'd0, 1);
    op("exact_1x1", 1, 1, 1'b0, 64'd1, 8);
    // 1*1 lives in column 0, dropped; comp remains.
    op("approx_1x1", 1, 1, 1'b1, 64'd8, 8);
    op("approx_16x16", 16, 16, 1'b1, 64'd264, 8);

    // Back-pressure in DONE with a pending new operand.
    start(5, 6, 1'b0);
    wait_out(lat);
    chk("bp_lat", 64'(lat), 64'(8));
    chk("bp_res", 64'(bus.out_result), 64'd30);
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd7;
    bus.in_b      = 8'd9;
    bus.in_approx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_hold", 64'(bus.out_result), 64'd30);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_vld_drop", 64'(bus.out_valid), 64'(0));
    chk("bp_idle_ready", 64'(bus.in_ready), 64'(1));
    chk("bp_res_keep", 64'(bus.out_result), 64'd30);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_accept", 64'(bus.in_ready), 64'(0));
    wait_out(lat);
    chk("bp2_lat", 64'(lat), 64'(8));
    chk("bp2_res", 64'(bus.out_result), 64'd63);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset during the third BUSY cycle.
    start(200, 100, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_res", 64'(bus.out_result), 64'(0));
    chk("mid_rst_ready", 64'(bus.in_ready), 64'(1));
    #2;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_quiet", 64'(bus.out_valid), 64'(0));
    end
    op("after_rst", 3, 5, 1'b0, 64'd15, 8);

    for (int k = 0; k < 300; k++) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      ap = k[0];
      op(ap ? "rnd_apx" : "rnd_ex", a, b, ap, model(a, b, ap),
         (a == 0 || b == 0) ? 1 : 8);
      if (ap && a != 0 && b != 0) begin
        err = longint'(a * b) - longint'(model(a, b, 1'b1));
        if (err < 0) err = -err;
        chk("rnd_err_bound", 64'(err <= 128), 64'(1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
